// File: rtl/step_sequencer_if.sv
// ============================================================================
// step_sequencer_if : control, pattern-write and tone-output bus of the
// step sequencer. Optional oneshot/done pair under STEP_SEQ_ONESHOT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

interface step_sequencer_if #(
  parameter int STEPS    = 8,
  parameter int PERIOD_W = 16
);
  localparam int ADDR_W = $clog2(STEPS);

  logic                start;
  logic                stop;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [PERIOD_W-1:0] wr_data;
  logic [PERIOD_W-1:0] tone_period;
  logic                tone_load;
  logic                gate;
  logic [ADDR_W-1:0]   step_idx;
  logic                step_tick;
  logic                running;

`ifdef STEP_SEQ_ONESHOT_EN
  logic                oneshot;
  logic                done;

  modport master (
    output start, stop, wr_en, wr_addr, wr_data, oneshot,
    input  tone_period, tone_load, gate, step_idx, step_tick, running, done
  );
  modport slave (
    input  start, stop, wr_en, wr_addr, wr_data, oneshot,
    output tone_period, tone_load, gate, step_idx, step_tick, running, done
  );
`else
  modport master (
    output start, stop, wr_en, wr_addr, wr_data,
    input  tone_period, tone_load, gate, step_idx, step_tick, running
  );
  modport slave (
    input  start, stop, wr_en, wr_addr, wr_data,
    output tone_period, tone_load, gate, step_idx, step_tick, running
  );
`endif
endinterface

`default_nettype wire

// File: rtl/step_sequencer.sv
// ============================================================================
// step_sequencer : tempo-driven pattern sequencer feeding a tone divider.
// Optional single-pass playback with done pulse: define STEP_SEQ_ONESHOT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module step_sequencer #(
  parameter int TICK_DIV    = 6_750_000,
  parameter int GATE_CYCLES = 3_375_000,
  parameter int STEPS       = 8,
  parameter int PERIOD_W    = 16
) (
  input  wire              clk_27Mhz,
  input  wire              reset,
  step_sequencer_if.slave  bus
);

  localparam int ADDR_W = $clog2(STEPS);
  localparam int CNT_W  = $clog2(TICK_DIV);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_RUN      = 2'd1;
  localparam logic [1:0] c_STOPPING = 2'd2;

  localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  c_GATE     = CNT_W'(GATE_CYCLES);
  localparam logic [ADDR_W-1:0] c_IDX_LAST = ADDR_W'(STEPS - 1);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_idx;
  logic [PERIOD_W-1:0] r_ram [STEPS];
  logic [PERIOD_W-1:0] r_period;
  logic                r_load;
  logic                r_gate;
  logic                r_tick;
  logic                r_active;

  logic [1:0]          w_state_nx;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [ADDR_W-1:0]   w_idx_nx;
  logic                w_enter;
  logic                w_last;
  logic                w_start_ok;
  logic                w_oneshot_end;
  logic                w_active_nx;
  logic [PERIOD_W-1:0] w_entry;

`ifdef STEP_SEQ_ONESHOT_EN
  logic r_oneshot;
  logic r_done;
  assign w_oneshot_end = r_oneshot && (r_idx == c_IDX_LAST);
  assign bus.done      = r_done;
`else
  assign w_oneshot_end = 1'b0;
`endif

  assign w_last     = (r_cnt == c_CNT_LAST);
  assign w_start_ok = bus.start && !bus.stop;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_enter    = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_start_ok) begin
          w_state_nx = c_RUN;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
          w_enter    = 1'b1;
        end
      end
      c_RUN: begin
        w_cnt_nx = w_last ? '0 : r_cnt + 1'b1;
        // A stop on the final cycle of a step ends playback at that step's boundary
        if (w_last) begin
          if (bus.stop || w_oneshot_end) begin
            w_state_nx = c_IDLE;
          end else begin
            w_idx_nx = r_idx + 1'b1;
            w_enter  = 1'b1;
          end
        end else if (bus.stop) begin
          w_state_nx = c_STOPPING;
        end
      end
      c_STOPPING: begin
        w_cnt_nx = w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          w_state_nx = c_IDLE;
        end
      end
      default: begin
        w_state_nx = c_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Read before this edge's write lands, so a same-cycle write plays on the next visit
  assign w_entry     = r_ram[w_idx_nx];
  assign w_active_nx = w_enter ? (w_entry != '0) : r_active;

  always_ff @(posedge clk_27Mhz) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_period <= '0;
      r_load   <= 1'b0;
      r_gate   <= 1'b0;
      r_tick   <= 1'b0;
      r_active <= 1'b0;
      for (int i = 0; i < STEPS; i++) begin
        r_ram[i] <= '0;
      end
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_idx    <= w_idx_nx;
      r_active <= w_active_nx;
      r_load   <= w_enter && (w_entry != '0);
      r_tick   <= (w_state_nx != c_IDLE) && (w_cnt_nx == c_CNT_LAST);
      r_gate   <= (w_state_nx == c_RUN) && (w_cnt_nx < c_GATE) && w_active_nx;
      if (w_enter && (w_entry != '0)) begin
        r_period <= w_entry;
      end
      if (bus.wr_en) begin
        r_ram[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

`ifdef STEP_SEQ_ONESHOT_EN
  always_ff @(posedge clk_27Mhz) begin
    if (reset) begin
      r_oneshot <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if ((r_state == c_IDLE) && w_start_ok) begin
        r_oneshot <= bus.oneshot;
      end
      r_done <= (r_state != c_IDLE) && (w_state_nx == c_IDLE);
    end
  end
`endif

  assign bus.tone_period = r_period;
  assign bus.tone_load   = r_load;
  assign bus.gate        = r_gate;
  assign bus.step_idx    = r_idx;
  assign bus.step_tick   = r_tick;
  assign bus.running     = (r_state != c_IDLE);

endmodule

`default_nettype wire
